sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Two-port round-robin arbiter in front of a single-access SRAM
//            controller. Captures the winning request, issues one strobe,
//            waits for the controller to finish and returns read data.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,        // asynchronous, active-low

    // Requester 0
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,

    // Requester 1
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,

    // SRAM controller side
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_write,
    output logic              write,
    output logic              read,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_read,

    output logic              busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_BLANK = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q,      state_d;
    logic              last_grant_q, last_grant_d;  // port granted most recently
    logic              port_q,       port_d;        // port being served
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [DATA_W-1:0] rdata0_q,     rdata0_d;
    logic [DATA_W-1:0] rdata1_q,     rdata1_d;

    logic w_any_req;
    logic w_winner;

    // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        w_any_req = req0 | req1;
        if (req0 && req1) begin
            w_winner = ~last_grant_q;
        end else begin
            w_winner = req1;
        end
    end

    // Next-state and datapath capture for the access sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            S_IDLE: begin
                // Requester inputs are only looked at here; later changes are ignored.
                if (w_any_req && ready) begin
                    state_d      = S_ISSUE;
                    port_d       = w_winner;
                    last_grant_d = w_winner;
                    we_d         = w_winner ? we1    : we0;
                    addr_d       = w_winner ? addr1  : addr0;
                    wdata_d      = w_winner ? wdata1 : wdata0;
                end
            end
            S_ISSUE: begin
                state_d = S_BLANK;
            end
            S_BLANK: begin
                // Controller drops ready a cycle after the strobe; skip this stale cycle.
                state_d = S_BLANK + 3'd1;
            end
            S_WAIT: begin
                if (ready) begin
                    state_d = S_DONE;
                    // Read data is valid with ready, so it lands in rdata alongside done.
                    if (!we_q) begin
                        if (port_q) begin
                            rdata1_d = data_read;
                        end else begin
                            rdata0_d = data_read;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any access in flight without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Pulses decode directly from registered state, so reset clears them at once.
    always_comb begin
        gnt0       = (state_q == S_ISSUE) && !port_q;
        gnt1       = (state_q == S_ISSUE) &&  port_q;
        write      = (state_q == S_ISSUE) &&  we_q;
        read       = (state_q == S_ISSUE) && !we_q;
        done0      = (state_q == S_DONE)  && !port_q;
        done1      = (state_q == S_DONE)  &&  port_q;
        busy       = (state_q != S_IDLE);
        address    = addr_q;
        data_write = wdata_q;
        rdata0     = rdata0_q;
        rdata1     = rdata1_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Self-checking bench for sram_arbiter with a behavioural SRAM
//            controller and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, done0, done1, write, read, busy;
    logic [DW-1:0] rdata0, rdata1, data_write, data_read;
    logic [AW-1:0] address;
    logic          ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural SRAM controller: ready falls the edge after a strobe, rises after lat cycles.
    logic [DW-1:0] mem [0:255];
    logic          ctl_ready;
    int            ctl_cnt;
    int            ctl_next_lat = 4;
    logic [7:0]    ctl_addr;
    logic          ctl_we;
    logic          block = 1'b0;

    assign ready = ctl_ready & ~block;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .address(address), .data_write(data_write), .write(write), .read(read),
        .ready(ready), .data_read(data_read), .busy(busy)
    );

    // Controller model.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_ready <= 1'b1;
            ctl_cnt   <= 0;
            ctl_addr  <= '0;
            ctl_we    <= 1'b0;
            data_read <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (write || read) begin
            ctl_ready <= 1'b0;
            ctl_cnt   <= ctl_next_lat;
            ctl_addr  <= address[7:0];
            ctl_we    <= write;
            if (write) mem[address[7:0]] <= data_write;
        end else if (ctl_cnt == 1) begin
            ctl_ready <= 1'b1;
            ctl_cnt   <= 0;
            if (!ctl_we) data_read <= mem[ctl_addr];
        end else if (ctl_cnt > 1) begin
            ctl_cnt <= ctl_cnt - 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({gnt0, gnt1, done0, done1, write, read, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0000000", {gnt0, gnt1, done0, done1, write, read, busy});
        end
        n_checks++;
        if (address !== '0 || data_write !== '0 || rdata0 !== '0 || rdata1 !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h dw=%h rd0=%h rd1=%h required all 0", address, data_write, rdata0, rdata1);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_write0();
        bit seen;
        int gc, strobes;
        req0 = 1'b1; we0 = 1'b1; addr0 = 18'h00000; wdata0 = 16'hAAAA; ctl_next_lat = 4;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (gnt0 === 1'b1) begin seen = 1; break; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL w0_gnt: gnt0 not seen, required within 5 cycles"); end
        n_checks++;
        if ({gnt1, write, read, address, data_write} !== {1'b0, 1'b1, 1'b0, 18'h00000, 16'hAAAA}) begin
            n_fail++;
            $display("FAIL w0_issue: gnt1=%b wr=%b rd=%b addr=%h dw=%h required 0 1 0 00000 aaaa",
                     gnt1, write, read, address, data_write);
        end
        // Requester moves on right after its grant; the access must not notice.
        req0 = 1'b0; we0 = 1'b0; addr0 = 18'h3FFFF; wdata0 = 16'h5555;
        seen = 0; gc = 0; strobes = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); gc++;
            if (write || read) strobes++;
            n_checks++;
            if (address !== 18'h00000 || data_write !== 16'hAAAA) begin
                n_fail++;
                $display("FAIL w0_hold: addr=%h dw=%h required 00000 aaaa", address, data_write);
            end
            if (done0 === 1'b1) begin seen = 1; break; end
        end
        n_checks++;
        if (!seen || gc != 6) begin n_fail++; $display("FAIL w0_latency: done0 after %0d cycles (seen=%0d) required 6", gc, seen); end
        n_checks++;
        if (strobes != 0) begin n_fail++; $display("FAIL w0_strobes: %0d extra strobes required 0", strobes); end
        n_checks++;
        if (rdata0 !== '0) begin n_fail++; $display("FAIL w0_rdata: rdata0=%h required 0000", rdata0); end
        tick();
    endtask

    task automatic test_read1();
        bit seen;
        int gc, reads;
        // Put 0x0A0A at 0x10 through port 0 first.
        req0 = 1'b1; we0 = 1'b1; addr0 = 18'h00010; wdata0 = 16'h0A0A; ctl_next_lat = 1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (gnt0 === 1'b1) begin seen = 1; break; end end
        req0 = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); if (done0 === 1'b1) begin seen = seen & 1'b1; break; end end
        tick();
        req1 = 1'b1; we1 = 1'b0; addr1 = 18'h00010; wdata1 = 16'h1111; ctl_next_lat = 2;
        seen = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (gnt1 === 1'b1) begin seen = 1; break; end end
        n_checks++;
        if (!seen || read !== 1'b1 || write !== 1'b0 || address !== 18'h00010) begin
            n_fail++;
            $display("FAIL r1_issue: seen=%0d rd=%b wr=%b addr=%h required 1 1 0 00010", seen, read, write, address);
        end
        req1 = 1'b0;
        seen = 0; gc = 0; reads = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); gc++;
            if (read || write) reads++;
            if (done0 === 1'b1) reads += 100;
            if (done1 === 1'b1) begin seen = 1; break; end
        end
        n_checks++;
        if (!seen || gc != 4 || reads != 0) begin
            n_fail++;
            $display("FAIL r1_done: seen=%0d after %0d cycles stray=%0d required 1 after 4, stray 0", seen, gc, reads);
        end
        repeat (3) tick();
        n_checks++;
        if (rdata1 !== 16'h0A0A || rdata0 !== 16'h0000) begin
            n_fail++;
            $display("FAIL r1_rdata: rdata1=%h rdata0=%h required 0a0a 0000", rdata1, rdata0);
        end
    endtask

    task automatic test_ready_block();
        int gseen;
        block = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 18'h00005; wdata0 = 16'h1234; ctl_next_lat = 1;
        gseen = 0;
        repeat (5) begin tick(); if (gnt0 || gnt1) gseen++; end
        n_checks++;
        if (gseen != 0) begin n_fail++; $display("FAIL blk_nogrant: %0d grants while ready=0 required 0", gseen); end
        block = 1'b0;
        tick();
        n_checks++;
        if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL blk_grant: gnt0=%b after ready rose required 1", gnt0); end
        req0 = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); if (!busy) break; end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL blk_drain: busy=%b required 0", busy); end
    endtask

    task automatic test_round_robin();
        int order [4];
        int ng, both;
        reset = 1'b0; tick(); reset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 18'h00001;
        req1 = 1'b1; we1 = 1'b0; addr1 = 18'h00002;
        ctl_next_lat = 1;
        ng = 0; both = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            tick();
            if (gnt0 && gnt1) both++;
            if (gnt0) begin order[ng] = 0; ng++; end
            else if (gnt1) begin order[ng] = 1; ng++; end
        end
        n_checks++;
        if (ng != 4 || both != 0) begin n_fail++; $display("FAIL rr_count: grants=%0d double=%0d required 4 0", ng, both); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k < ng && order[k] != (k % 2)) begin
                n_fail++;
                $display("FAIL rr_order: grant %0d went to port %0d required %0d", k, order[k], k % 2);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); if (!busy) break; end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_drain: busy=%b required 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int dseen;
        req1 = 1'b1; we1 = 1'b0; addr1 = 18'h00020; ctl_next_lat = 4;
        seen = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (gnt1 === 1'b1) begin seen = 1; break; end end
        tick(); tick();
        n_checks++;
        if (!seen || busy !== 1'b1) begin n_fail++; $display("FAIL rm_setup: gnt seen=%0d busy=%b required 1 1", seen, busy); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({gnt0, gnt1, done0, done1, write, read, busy} !== 7'b0 || address !== '0 || data_write !== '0
            || rdata0 !== '0 || rdata1 !== '0) begin
            n_fail++;
            $display("FAIL rm_async: ctrl=%b addr=%h dw=%h rd0=%h rd1=%h required all 0",
                     {gnt0, gnt1, done0, done1, write, read, busy}, address, data_write, rdata0, rdata1);
        end
        addr1 = 18'h00021;
        dseen = 0;
        repeat (3) begin tick(); if (done0 || done1) dseen++; end
        n_checks++;
        if (dseen != 0) begin n_fail++; $display("FAIL rm_nodone: %0d done pulses in reset required 0", dseen); end
        reset = 1'b1;
        tick();
        n_checks++;
        if (gnt1 !== 1'b1 || address !== 18'h00021) begin
            n_fail++;
            $display("FAIL rm_regrant: gnt1=%b addr=%h required 1 00021", gnt1, address);
        end
        req1 = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); if (!busy) break; end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_drain: busy=%b required 0", busy); end
    endtask

    // Random traffic against a transaction-level model of the arbiter.
    task automatic test_random();
        logic [DW-1:0] ref_mem [0:255];
        logic [DW-1:0] exp_rd  [0:1];
        logic [DW-1:0] cap_wdata, cap_rval;
        logic [AW-1:0] cap_addr;
        logic [6:0]    exp_vec, got_vec;
        bit act, busy_prev, last, win, cap_we, p_ready, eg, ed;
        int g, done_c;
        reset = 1'b0; block = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        act = 0; busy_prev = 0; last = 1; win = 0; cap_we = 0; g = 0; done_c = -1;
        cap_addr = '0; cap_wdata = '0; cap_rval = '0;
        p_ready = ctl_ready;
        for (int c = 1; c <= 500; c++) begin
            tick();
            eg = 0; ed = 0;
            if (act && done_c >= 0 && c > done_c) begin
                act = 0;
                if (!cap_we) exp_rd[win] = cap_rval;
            end
            if (!busy_prev && (req0 || req1) && p_ready) begin
                eg = 1;
                win = (req0 && req1) ? ~last : req1;
                last = win; act = 1; g = c; done_c = -1;
                cap_we    = win ? we1    : we0;
                cap_addr  = win ? addr1  : addr0;
                cap_wdata = win ? wdata1 : wdata0;
                if (cap_we) ref_mem[cap_addr[7:0]] = cap_wdata;
                else        cap_rval = ref_mem[cap_addr[7:0]];
                ctl_next_lat = $urandom_range(1, 4);
            end else if (act && done_c < 0 && c >= g + 3 && p_ready) begin
                ed = 1; done_c = c;
            end
            exp_vec = {eg && !win, eg && win, eg && cap_we, eg && !cap_we, ed && !win, ed && win, act};
            got_vec = {gnt0, gnt1, write, read, done0, done1, busy};
            n_checks++;
            if (got_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rnd_ctrl: cycle %0d {g0,g1,wr,rd,d0,d1,busy}=%b required %b", c, got_vec, exp_vec);
            end
            if (act) begin
                n_checks++;
                if (address !== cap_addr || data_write !== cap_wdata) begin
                    n_fail++;
                    $display("FAIL rnd_bus: cycle %0d addr=%h dw=%h required %h %h", c, address, data_write, cap_addr, cap_wdata);
                end
            end
            if (c != done_c) begin
                n_checks++;
                if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
                    n_fail++;
                    $display("FAIL rnd_rdata: cycle %0d rd0=%h rd1=%h required %h %h", c, rdata0, rdata1, exp_rd[0], exp_rd[1]);
                end
            end
            busy_prev = act;
            // Drive the inputs seen at the next edge; requesters churn freely.
            req0   = (c < 470) && ($urandom_range(0, 9) < 6);
            req1   = (c < 470) && ($urandom_range(0, 9) < 6);
            we0    = 1'($urandom);
            we1    = 1'($urandom);
            addr0  = 18'($urandom) & 18'h3FF0F;
            addr1  = 18'($urandom) & 18'h3FF0F;
            wdata0 = 16'($urandom);
            wdata1 = 16'($urandom);
            block  = ($urandom_range(0, 7) == 0);
            p_ready = ctl_ready & ~block;
        end
        block = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write0();
        test_read1();
        test_ready_block();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
